// File: rtl/mmapkron_stream_sequencer.sv
// mMapKron job sequencer: serialises NUM_IN operand packets in channel order onto the core
// input stream, then waits for the core's result pointer and reports job statistics.
module mmapkron_stream_sequencer #(
  parameter int DATA_W  = 67,
  parameter int NUM_IN  = 2,
  parameter int RES_W   = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  input  logic [NUM_IN*DATA_W-1:0] s_tdata,
  input  logic [NUM_IN-1:0]        s_tvalid,
  input  logic [NUM_IN-1:0]        s_tlast,
  output logic [NUM_IN-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  input  logic [RES_W-1:0]         r_tdata,
  input  logic                     r_tvalid,
  output logic                     r_tready,
  output logic [RES_W-1:0]         result,
  output logic [CNT_W-1:0]         cycles,
  output logic [CNT_W-1:0]         tok_count
);
  localparam int                CH_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_WAIT_RES, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [CNT_W-1:0]   tok_q, tok_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               error_q, error_d;

  logic               feed;
  logic               fire;
  logic [DATA_W-1:0]  ch_data [NUM_IN];

  assign feed = (state_q == ST_FEED);
  assign fire = m_tvalid && m_tready;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ch
    assign ch_data[gi]  = s_tdata[gi*DATA_W +: DATA_W];
    assign s_tready[gi] = feed && (ch_q == CH_W'(gi)) && m_tready;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      result_q <= '0;
      cycles_q <= '0;
      tok_q    <= '0;
      wait_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
      tok_q    <= tok_d;
      wait_q   <= wait_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    result_d = result_q;
    cycles_d = cycles_q;
    tok_d    = tok_q;
    wait_d   = wait_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FEED;
          ch_d     = '0;
          // The start-acceptance cycle is the first cycle of the job.
          cycles_d = CNT_W'(1);
          tok_d    = '0;
          error_d  = 1'b0;
        end
      end
      ST_FEED: begin
        cycles_d = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + 1'b1;
        if (fire) begin
          tok_d = (tok_q == CNT_MAX) ? tok_q : tok_q + 1'b1;
          if (m_tlast) begin
            if (ch_q == LAST_CH) begin
              state_d = ST_WAIT_RES;
              wait_d  = '0;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end
        end
      end
      ST_WAIT_RES: begin
        cycles_d = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + 1'b1;
        if (r_tvalid) begin
          result_d = r_tdata;
          state_d  = ST_DONE;
        end else if ((TIMEOUT != 0) && (wait_q == TO_LAST)) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = (wait_q == CNT_MAX) ? wait_q : wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    r_tready = (state_q == ST_WAIT_RES);
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    if (feed) begin
      m_tdata  = ch_data[ch_q];
      m_tvalid = s_tvalid[ch_q];
      m_tlast  = s_tlast[ch_q];
    end
  end

  assign error     = error_q;
  assign result    = result_q;
  assign cycles    = cycles_q;
  assign tok_count = tok_q;

endmodule

// File: tb/tb_mmapkron_stream_sequencer.sv
// Bench for mmapkron_stream_sequencer: a directed table for the basic job, randomized jobs
// against a packet-level reference model, and hand-written reset/timeout sequences.
module tb_mmapkron_stream_sequencer;
  localparam int DW = 67;
  localparam int NI = 2;
  localparam int RW = 32;
  localparam int CW = 32;
  localparam int TO = 16;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              start;
  logic              busy, done, error;
  logic [NI*DW-1:0]  s_tdata;
  logic [NI-1:0]     s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tlast, m_tready;
  logic [RW-1:0]     r_tdata;
  logic              r_tvalid, r_tready;
  logic [RW-1:0]     result;
  logic [CW-1:0]     cycles, tok_count;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_result;

  always #5 aclk = ~aclk;

  mmapkron_stream_sequencer #(
    .DATA_W(DW), .NUM_IN(NI), .RES_W(RW), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done), .error(error),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready),
    .result(result), .cycles(cycles), .tok_count(tok_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_tok();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_error"}, error, 1'b0);
    chk({tag, "_s_tready"}, 128'(s_tready), 128'(0));
    chk1({tag, "_m_tvalid"}, m_tvalid, 1'b0);
    chk1({tag, "_m_tlast"}, m_tlast, 1'b0);
    chk1({tag, "_r_tready"}, r_tready, 1'b0);
    chk({tag, "_result"}, 128'(result), 128'(0));
    chk({tag, "_cycles"}, 128'(cycles), 128'(0));
    chk({tag, "_tok_count"}, 128'(tok_count), 128'(0));
  endtask

  typedef struct {
    logic          start;
    logic [1:0]    tv, tl;
    logic [DW-1:0] d0, d1;
    logic          mr, rv;
    logic [RW-1:0] rd;
    logic [1:0]    e_sr;
    logic          e_mv, e_ml;
    logic [DW-1:0] e_md;
    logic          e_rr, e_busy, e_done;
  } vec_t;

  function automatic vec_t mk(
      input logic st, input logic [1:0] tv, input logic [1:0] tl,
      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic mr,
      input logic rv, input logic [RW-1:0] rd, input logic [1:0] e_sr,
      input logic e_mv, input logic e_ml, input logic [DW-1:0] e_md,
      input logic e_rr, input logic e_busy, input logic e_done);
    vec_t v;
    v.start = st; v.tv = tv; v.tl = tl; v.d0 = d0; v.d1 = d1; v.mr = mr;
    v.rv = rv; v.rd = rd; v.e_sr = e_sr; v.e_mv = e_mv; v.e_ml = e_ml;
    v.e_md = e_md; v.e_rr = e_rr; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  // Basic job: ch0 sends A0..A2, ch1 (valid early) sends B0,B1; result 0x5 four cycles later.
  task automatic run_table();
    vec_t tbl [12];
    logic [DW-1:0] a0, a1, a2, b0, b1, z;
    a0 = 67'h5_1234_5678_9ABC_DEF0;
    a1 = 67'h2_0000_0000_0000_00A1;
    a2 = 67'h7_FFFF_0000_FFFF_00A2;
    b0 = 67'h1_0000_0000_0000_00B0;
    b1 = 67'h0_0000_0000_0000_00B1;
    z  = '0;
    tbl[0]  = mk(1, 2'b00, 2'b00, z,  z,  1, 1, 32'h77, 2'b00, 0, 0, z,  0, 0, 0);
    tbl[1]  = mk(0, 2'b11, 2'b00, a0, b0, 1, 0, 32'h0,  2'b01, 1, 0, a0, 0, 1, 0);
    tbl[2]  = mk(1, 2'b11, 2'b00, a1, b0, 1, 0, 32'h0,  2'b01, 1, 0, a1, 0, 1, 0);
    tbl[3]  = mk(0, 2'b11, 2'b01, a2, b0, 1, 0, 32'h0,  2'b01, 1, 1, a2, 0, 1, 0);
    tbl[4]  = mk(0, 2'b10, 2'b00, z,  b0, 1, 0, 32'h0,  2'b10, 1, 0, b0, 0, 1, 0);
    tbl[5]  = mk(0, 2'b10, 2'b10, z,  b1, 1, 1, 32'h99, 2'b10, 1, 1, b1, 0, 1, 0);
    tbl[6]  = mk(1, 2'b00, 2'b00, z,  z,  1, 0, 32'h0,  2'b00, 0, 0, z,  1, 1, 0);
    tbl[7]  = mk(0, 2'b00, 2'b00, z,  z,  1, 0, 32'h0,  2'b00, 0, 0, z,  1, 1, 0);
    tbl[8]  = mk(0, 2'b00, 2'b00, z,  z,  1, 0, 32'h0,  2'b00, 0, 0, z,  1, 1, 0);
    tbl[9]  = mk(0, 2'b00, 2'b00, z,  z,  1, 1, 32'h5,  2'b00, 0, 0, z,  1, 1, 0);
    tbl[10] = mk(0, 2'b00, 2'b00, z,  z,  1, 0, 32'h0,  2'b00, 0, 0, z,  0, 1, 1);
    tbl[11] = mk(0, 2'b00, 2'b00, z,  z,  1, 0, 32'h0,  2'b00, 0, 0, z,  0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      @(posedge aclk); #1;
      start = tbl[i].start; s_tvalid = tbl[i].tv; s_tlast = tbl[i].tl;
      s_tdata = {tbl[i].d1, tbl[i].d0}; m_tready = tbl[i].mr;
      r_tvalid = tbl[i].rv; r_tdata = tbl[i].rd;
      #1;
      $display("table row %0d: s_tready=%b m_tvalid=%b m_tdata=%0h busy=%b done=%b",
               i, s_tready, m_tvalid, m_tdata, busy, done);
      chk("tbl_s_tready", 128'(s_tready), 128'(tbl[i].e_sr));
      chk1("tbl_m_tvalid", m_tvalid, tbl[i].e_mv);
      chk1("tbl_r_tready", r_tready, tbl[i].e_rr);
      chk1("tbl_busy", busy, tbl[i].e_busy);
      chk1("tbl_done", done, tbl[i].e_done);
      if (tbl[i].e_mv) begin
        chk1("tbl_m_tlast", m_tlast, tbl[i].e_ml);
        chk("tbl_m_tdata", 128'(m_tdata), 128'(tbl[i].e_md));
      end
    end
    chk("tbl_result", 128'(result), 128'(32'h5));
    chk("tbl_tok_count", 128'(tok_count), 128'(5));
    chk("tbl_cycles", 128'(cycles), 128'(10));
    chk1("tbl_error", error, 1'b0);
    exp_result = 32'h5;
  endtask

  // Random job: packets per channel, random valids/readies, result after res_delay wait cycles.
  task automatic run_job(input int res_delay, input bit toggle);
    logic [DW-1:0] pkt [NI][4];
    int plen [NI];
    int ptr [NI];
    logic [DW-1:0] sq_data [$];
    bit sq_last [$];
    int sq_ch [$];
    int pos, phase, w, ncyc, cur;
    bit exp_err;
    for (int c = 0; c < NI; c++) begin
      plen[c] = $urandom_range(1, 4);
      ptr[c] = 0;
      for (int k = 0; k < plen[c]; k++) begin
        pkt[c][k] = rand_tok();
        sq_data.push_back(pkt[c][k]);
        sq_last.push_back(k == plen[c] - 1);
        sq_ch.push_back(c);
      end
    end
    @(posedge aclk); #1;
    start = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    r_tvalid = 1'b1; r_tdata = $urandom();
    #1;
    chk1("idle_r_tready", r_tready, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    @(posedge aclk); #1;
    start = 1'b0;
    pos = 0; phase = 1; w = 0; ncyc = 1; exp_err = 1'b0;
    for (int n = 0; n < 400 && phase != 3; n++) begin
      start = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < NI; c++) begin
        if (ptr[c] < plen[c]) begin
          s_tvalid[c] = ($urandom_range(0, 3) != 0);
          s_tdata[c*DW +: DW] = pkt[c][ptr[c]];
          s_tlast[c] = (ptr[c] == plen[c] - 1);
        end else begin
          s_tvalid[c] = 1'b0;
          s_tlast[c] = 1'b0;
        end
      end
      m_tready = toggle ? (n % 2 == 0) : ($urandom_range(0, 3) != 0);
      r_tdata = $urandom();
      r_tvalid = (phase == 1) ? ($urandom_range(0, 3) == 0) : (w >= res_delay);
      #1;
      chk1("job_busy", busy, 1'b1);
      chk1("job_done", done, 1'b0);
      if (n == 0) chk1("job_error_cleared", error, 1'b0);
      chk1("job_r_tready", r_tready, phase == 2);
      if (phase == 1) begin
        cur = sq_ch[pos];
        chk("job_s_tready", 128'(s_tready), 128'(m_tready) << cur);
        chk1("job_m_tvalid", m_tvalid, s_tvalid[cur]);
        if (s_tvalid[cur]) begin
          chk1("job_m_tlast", m_tlast, sq_last[pos]);
          chk("job_m_tdata", 128'(m_tdata), 128'(sq_data[pos]));
          if (m_tready) begin
            ptr[cur]++;
            pos++;
            if (pos == sq_data.size()) begin
              phase = 2;
              w = 0;
            end
          end
        end
      end else begin
        chk1("wait_m_tvalid", m_tvalid, 1'b0);
        chk("wait_s_tready", 128'(s_tready), 128'(0));
        if (r_tvalid) begin
          exp_result = r_tdata;
          phase = 3;
        end else if (w == TO - 1) begin
          exp_err = 1'b1;
          phase = 3;
        end else begin
          w++;
        end
      end
      ncyc++;
      @(posedge aclk); #1;
    end
    checks++;
    if (phase != 3) begin
      errors++;
      $display("FAIL job_bound: model phase %0d required 3", phase);
    end
    start = 1'b0; s_tvalid = '0; s_tlast = '0; r_tvalid = 1'b0;
    #1;
    chk1("done_pulse", done, 1'b1);
    chk1("done_busy", busy, 1'b1);
    chk1("done_r_tready", r_tready, 1'b0);
    @(posedge aclk); #2;
    chk1("after_done", done, 1'b0);
    chk1("after_busy", busy, 1'b0);
    chk("job_result", 128'(result), 128'(exp_result));
    chk("job_cycles", 128'(cycles), 128'(ncyc));
    chk("job_tok_count", 128'(tok_count), 128'(sq_data.size()));
    chk1("job_error", error, exp_err);
    $display("job: tokens=%0d delay=%0d toggle=%0b cycles=%0d error=%b result=%0h",
             sq_data.size(), res_delay, toggle, cycles, error, result);
  endtask

  task automatic reset_mid_feed();
    @(posedge aclk); #1;
    start = 1'b1; s_tvalid = '0; s_tlast = '0; r_tvalid = 1'b0; m_tready = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_tvalid = 2'b01; s_tlast = 2'b00; s_tdata = {rand_tok(), rand_tok()};
      @(posedge aclk); #1;
    end
    #1;
    chk("mid_tok_count", 128'(tok_count), 128'(2));
    s_tvalid = 2'b11;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_result = '0;
    s_tvalid = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #2;
      chk1("midrst_no_done", done, 1'b0);
      chk1("midrst_idle", busy, 1'b0);
    end
    $display("reset mid-feed: outputs back to reset values");
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0;
    m_tready = 1'b0; r_tdata = '0; r_tvalid = 1'b0; exp_result = '0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    check_reset_outputs("reset");
    run_table();
    run_job(2, 1'b0);
    run_job(3, 1'b1);
    run_job(1000, 1'b0);
    run_job(1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      run_job(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end
    reset_mid_feed();
    run_job(0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
